writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 mem  mem_out_if.other  --  memory-stage outputs: pc, nextpc, res, rd, w_rd, cmp_res, w_cr, op3, alu_res, mtsr, scall, eret, udf, bubble, stall.
REQ-004 rf_we / rf_waddr / rf_wdata  output  1/5/32  register-file write port.
REQ-005 cr_we / cr_wdata  output  1/2  condition-register write port.
REQ-006 redirect / redirect_pc  output  1/32  front-end PC override, registered.
REQ-007 flush  output  1  squash all younger pipeline stages, registered.
REQ-008 sr_epc, sr_cause, sr_status, sr_evec  output  32 each  system-register contents.
REQ-009 instret  output  64  retired-instruction counter.

Function
REQ-010 An instruction is valid when !bubble && !stall && state==RUN.
REQ-011 rf_we = valid && w_rd && rd!=0 && no exception; rf_waddr=rd, rf_wdata=res; combinational, zero latency.
REQ-012 cr_we = valid && w_cr && no exception; cr_wdata=cmp_res; combinational.
REQ-013 Exception priority: udf > scall > eret; only the winning event is acted on.
REQ-014 udf: EPC<=pc, CAUSE<=2, STATUS[0]<=1, target=EVEC.
REQ-015 scall: EPC<=nextpc, CAUSE<=1, STATUS[0]<=1, target=EVEC.
REQ-016 eret: STATUS[0]<=0, target=EPC value before this edge.
REQ-017 An instruction that raises an exception or eret performs no rd, cr or mtsr write.
REQ-018 mtsr (valid, no exception): SR[op3[1:0]]<=alu_res; index 0=EPC, 1=CAUSE, 2=STATUS, 3=EVEC; upper op3 bits ignored.
REQ-019 A valid eret reads EPC as of the cycle it is accepted; an mtsr to EPC in the immediately preceding valid instruction is visible.
REQ-020 FSM states RUN, REDIR; RUN->REDIR on valid udf/scall/eret; REDIR->RUN unconditionally after exactly one cycle, independent of stall.
REQ-021 In REDIR: redirect=1, flush=1, redirect_pc=latched target; in RUN both 0, redirect_pc holds last target.
REQ-022 In REDIR the incoming mem bundle is ignored (wrong path): no writes, no counter increment.
REQ-023 instret increments by 1 on every valid instruction including mtsr and eret; not on udf/scall; wraps modulo 2^64.
REQ-024 stall or bubble in RUN: no writes, no state change, no increment.

Reset
REQ-025 On rst_n low, asynchronously: state=RUN, redirect=0, flush=0, redirect_pc=0, EPC=0, CAUSE=0, STATUS=1, EVEC=0x0000_0100, instret=0.
REQ-026 Reset during REDIR aborts the redirect; redirect/flush deassert immediately.
REQ-027 rf_we and cr_we are 0 while rst_n is low regardless of mem inputs.

Structure
REQ-028 A shared package holds the state enum, SR index constants, cause codes (CAUSE_SCALL=1, CAUSE_UDF=2) and EVEC reset value.
REQ-029 One sub-module, wb_sysregs, holds EPC/CAUSE/STATUS/EVEC and their write-priority logic; FSM and instret stay in writeback.

Verification
REQ-030 Valid w_rd=1, rd=5, res=0xDEADBEEF -> same-cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, instret 0->1; rd=0 -> rf_we=0, instret still increments.
REQ-031 scall at pc=0x1000, nextpc=0x1004 -> next cycle redirect=1, flush=1, redirect_pc=0x100, EPC=0x1004, CAUSE=1, STATUS=1; one cycle later redirect=0.
REQ-032 udf and scall both set, pc=0x2000, w_rd=1 -> EPC=0x2000, CAUSE=2, rf_we=0, instret unchanged.
REQ-033 mtsr op3=0, alu_res=0x3000, next valid instr eret -> redirect_pc=0x3000, STATUS[0]=0; valid w_rd instruction presented during REDIR -> rf_we=0.
REQ-034 stall=1 with w_rd=1, scall=1 for 3 cycles -> no writes, no redirect, instret unchanged; on stall release the scall is taken.
REQ-035 Assert rst_n low during REDIR -> redirect=0, flush=0, EVEC=0x100, instret=0 immediately, without a clock edge.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage and its system-register file.
package writeback_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } wb_state_e;

  localparam logic [1:0]  SR_EPC      = 2'd0;
  localparam logic [1:0]  SR_CAUSE    = 2'd1;
  localparam logic [1:0]  SR_STATUS   = 2'd2;
  localparam logic [1:0]  SR_EVEC     = 2'd3;

  localparam logic [31:0] CAUSE_SCALL = 32'd1;
  localparam logic [31:0] CAUSE_UDF   = 32'd2;
  localparam logic [31:0] EVEC_RST    = 32'h0000_0100;
  localparam logic [31:0] STATUS_RST  = 32'h0000_0001;

  // Trap events after priority resolution; at most one bit is set.
  typedef struct packed {
    logic udf;
    logic scall;
    logic eret;
  } wb_evt_t;

  function automatic wb_evt_t wb_resolve(input logic udf, input logic scall, input logic eret);
    wb_evt_t e;
    e.udf   = udf;
    e.scall = scall & ~udf;
    e.eret  = eret & ~udf & ~scall;
    return e;
  endfunction

endpackage

// File: rtl/mem_out_if.sv
// Memory-stage result bundle handed to writeback.
interface mem_out_if;
  logic [31:0] pc;
  logic [31:0] nextpc;
  logic [31:0] res;
  logic [4:0]  rd;
  logic        w_rd;
  logic [1:0]  cmp_res;
  logic        w_cr;
  logic [2:0]  op3;
  logic [31:0] alu_res;
  logic        mtsr;
  logic        scall;
  logic        eret;
  logic        udf;
  logic        bubble;
  logic        stall;

  modport other (
    input pc, nextpc, res, rd, w_rd, cmp_res, w_cr, op3, alu_res,
    input mtsr, scall, eret, udf, bubble, stall
  );

  modport mem (
    output pc, nextpc, res, rd, w_rd, cmp_res, w_cr, op3, alu_res,
    output mtsr, scall, eret, udf, bubble, stall
  );
endinterface

// File: rtl/wb_sysregs.sv
// EPC/CAUSE/STATUS/EVEC with trap-over-eret-over-mtsr write priority.
module wb_sysregs
  import writeback_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        udf,
  input  logic        scall,
  input  logic        eret,
  input  logic        mtsr,
  input  logic [1:0]  sr_idx,
  input  logic [31:0] sr_wdata,
  input  logic [31:0] pc,
  input  logic [31:0] nextpc,
  output logic [31:0] epc,
  output logic [31:0] cause,
  output logic [31:0] status,
  output logic [31:0] evec
);

  wb_evt_t evt;
  assign evt = wb_resolve(udf, scall, eret);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc    <= '0;
      cause  <= '0;
      status <= STATUS_RST;
      evec   <= EVEC_RST;
    end else if (valid) begin
      if (evt.udf) begin
        epc       <= pc;
        cause     <= CAUSE_UDF;
        status[0] <= 1'b1;
      end else if (evt.scall) begin
        // scall resumes after itself, so EPC captures the fall-through PC.
        epc       <= nextpc;
        cause     <= CAUSE_SCALL;
        status[0] <= 1'b1;
      end else if (evt.eret) begin
        status[0] <= 1'b0;
      end else if (mtsr) begin
        case (sr_idx)
          SR_EPC:    epc    <= sr_wdata;
          SR_CAUSE:  cause  <= sr_wdata;
          SR_STATUS: status <= sr_wdata;
          default:   evec   <= sr_wdata;
        endcase
      end
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: RF/CR write port, trap/eret redirect FSM, retired-instruction count.
module writeback
  import writeback_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  mem_out_if.other    mem,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        cr_we,
  output logic [1:0]  cr_wdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] sr_epc,
  output logic [31:0] sr_cause,
  output logic [31:0] sr_status,
  output logic [31:0] sr_evec,
  output logic [63:0] instret
);

  wb_state_e   state;
  logic        valid;
  logic        any_evt;
  logic        trap;
  logic        commit;
  logic [31:0] target;
  logic        op3_unused;

  assign op3_unused = mem.op3[2];

  assign valid   = !mem.bubble && !mem.stall && (state == RUN);
  assign any_evt = mem.udf || mem.scall || mem.eret;
  assign trap    = mem.udf || mem.scall;
  // Normal architectural writes only from a clean instruction; rst_n gates them while held.
  assign commit  = valid && !any_evt && rst_n;

  assign rf_we    = commit && mem.w_rd && (mem.rd != 5'd0);
  assign rf_waddr = mem.rd;
  assign rf_wdata = mem.res;
  assign cr_we    = commit && mem.w_cr;
  assign cr_wdata = mem.cmp_res;

  // EPC here is the pre-edge value, which already includes any mtsr from the prior instruction.
  assign target = trap ? sr_evec : sr_epc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      redirect    <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (valid && any_evt) begin
            state       <= REDIR;
            redirect    <= 1'b1;
            flush       <= 1'b1;
            redirect_pc <= target;
          end
        end
        default: begin
          state    <= RUN;
          redirect <= 1'b0;
          flush    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instret <= '0;
    else if (valid && !trap)
      instret <= instret + 64'd1;
  end

  wb_sysregs u_sysregs (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (valid),
    .udf      (mem.udf),
    .scall    (mem.scall),
    .eret     (mem.eret),
    .mtsr     (mem.mtsr),
    .sr_idx   (mem.op3[1:0]),
    .sr_wdata (mem.alu_res),
    .pc       (mem.pc),
    .nextpc   (mem.nextpc),
    .epc      (sr_epc),
    .cause    (sr_cause),
    .status   (sr_status),
    .evec     (sr_evec)
  );

endmodule

// File: tb/tb_writeback.sv
// Directed-vector bench for writeback; expectations queued by stimulus, checked by a monitor.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_we, cr_we, redirect, flush;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, redirect_pc, sr_epc, sr_cause, sr_status, sr_evec;
  logic [1:0]  cr_wdata;
  logic [63:0] instret;

  mem_out_if mif();

  writeback dut (
    .clk(clk), .rst_n(rst_n), .mem(mif),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cr_we(cr_we), .cr_wdata(cr_wdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .sr_epc(sr_epc), .sr_cause(sr_cause), .sr_status(sr_status), .sr_evec(sr_evec),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, nextpc, res, alu_res;
    logic [4:0]  rd;
    logic        w_rd, w_cr, mtsr, scall, eret, udf, bubble, stall;
    logic [1:0]  cmp_res;
    logic [2:0]  op3;
  } mem_t;

  typedef struct {
    string       name;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        cr_we;
    logic [1:0]  crd;
    logic        redir;
    logic [31:0] rpc, epc, cause, status, evec;
    logic [63:0] instret;
  } exp_t;

  exp_t sb[$];
  event sample_now;
  int   checks = 0;
  int   failures = 0;

  // Expected architectural state, advanced by hand after each step.
  logic        x_redir = 1'b0;
  logic [31:0] x_rpc = 0, x_epc = 0, x_cause = 0, x_status = 32'h1, x_evec = 32'h100;
  logic [63:0] x_instret = 0;

  function automatic mem_t nop();
    mem_t m;
    m.pc = 0; m.nextpc = 0; m.res = 0; m.alu_res = 0; m.rd = 0;
    m.w_rd = 0; m.w_cr = 0; m.mtsr = 0; m.scall = 0; m.eret = 0; m.udf = 0;
    m.bubble = 0; m.stall = 0; m.cmp_res = 0; m.op3 = 0;
    return m;
  endfunction

  function automatic exp_t mk(string nm, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic cwe, logic [1:0] cd);
    exp_t e;
    e.name = nm; e.rf_we = we; e.waddr = wa; e.wdata = wd; e.cr_we = cwe; e.crd = cd;
    e.redir = x_redir; e.rpc = x_rpc; e.epc = x_epc; e.cause = x_cause;
    e.status = x_status; e.evec = x_evec; e.instret = x_instret;
    return e;
  endfunction

  task automatic apply(input mem_t m);
    mif.pc = m.pc; mif.nextpc = m.nextpc; mif.res = m.res; mif.alu_res = m.alu_res;
    mif.rd = m.rd; mif.w_rd = m.w_rd; mif.w_cr = m.w_cr; mif.mtsr = m.mtsr;
    mif.scall = m.scall; mif.eret = m.eret; mif.udf = m.udf; mif.bubble = m.bubble;
    mif.stall = m.stall; mif.cmp_res = m.cmp_res; mif.op3 = m.op3;
  endtask

  task automatic step(input mem_t m, input exp_t e);
    @(posedge clk); #1;
    apply(m);
    sb.push_back(e);
  endtask

  task automatic chk(string nm, string fld, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: compares on every falling edge, or on demand for edge-free checks.
  always begin
    @(negedge clk or sample_now);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "rf_we",    rf_we,       e.rf_we);
      chk(e.name, "rf_waddr", rf_waddr,    e.waddr);
      chk(e.name, "rf_wdata", rf_wdata,    e.wdata);
      chk(e.name, "cr_we",    cr_we,       e.cr_we);
      chk(e.name, "cr_wdata", cr_wdata,    e.crd);
      chk(e.name, "redirect", redirect,    e.redir);
      chk(e.name, "flush",    flush,       e.redir);
      chk(e.name, "rpc",      redirect_pc, e.rpc);
      chk(e.name, "epc",      sr_epc,      e.epc);
      chk(e.name, "cause",    sr_cause,    e.cause);
      chk(e.name, "status",   sr_status,   e.status);
      chk(e.name, "evec",     sr_evec,     e.evec);
      chk(e.name, "instret",  instret,     e.instret);
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    mem_t m;
    // In reset with a writing instruction presented: write enables must stay low.
    m = nop(); m.w_rd = 1; m.rd = 5; m.res = 32'h11; m.w_cr = 1; m.cmp_res = 2'd3;
    apply(m);
    sb.push_back(mk("reset", 0, 5, 32'h11, 0, 2'd3));
    @(negedge clk); #1;
    m = nop(); m.bubble = 1; apply(m);
    #1 rst_n = 1'b1;

    m = nop(); m.w_rd = 1; m.rd = 5; m.res = 32'hDEADBEEF; m.w_cr = 1; m.cmp_res = 2'd2;
    step(m, mk("alu_rd5", 1, 5, 32'hDEADBEEF, 1, 2'd2));
    x_instret = 1;

    m = nop(); m.w_rd = 1; m.rd = 0; m.res = 32'h1;
    step(m, mk("alu_rd0", 0, 0, 32'h1, 0, 2'd0));
    x_instret = 2;

    m = nop(); m.bubble = 1; m.w_rd = 1; m.rd = 3; m.res = 32'h7; m.w_cr = 1;
    step(m, mk("bubble", 0, 3, 32'h7, 0, 2'd0));

    m = nop(); m.scall = 1; m.pc = 32'h1000; m.nextpc = 32'h1004;
    m.w_rd = 1; m.rd = 7; m.res = 32'h5;
    step(m, mk("scall", 0, 7, 32'h5, 0, 2'd0));
    x_redir = 1; x_rpc = 32'h100; x_epc = 32'h1004; x_cause = 32'h1; x_status = 32'h1;

    m = nop(); m.w_rd = 1; m.rd = 9; m.res = 32'h9; m.w_cr = 1; m.cmp_res = 2'd1;
    step(m, mk("scall_redir", 0, 9, 32'h9, 0, 2'd1));
    x_redir = 0;

    m = nop(); m.udf = 1; m.scall = 1; m.pc = 32'h2000; m.nextpc = 32'h2004;
    m.w_rd = 1; m.rd = 4; m.res = 32'h4;
    step(m, mk("udf_scall", 0, 4, 32'h4, 0, 2'd0));
    x_redir = 1; x_rpc = 32'h100; x_epc = 32'h2000; x_cause = 32'h2;

    m = nop(); m.bubble = 1;
    step(m, mk("udf_redir", 0, 0, 32'h0, 0, 2'd0));
    x_redir = 0;

    m = nop(); m.mtsr = 1; m.op3 = 3'b100; m.alu_res = 32'h3000;
    step(m, mk("mtsr_epc", 0, 0, 32'h0, 0, 2'd0));
    x_epc = 32'h3000; x_instret = 3;

    m = nop(); m.eret = 1; m.w_rd = 1; m.rd = 6; m.res = 32'h6; m.w_cr = 1;
    step(m, mk("eret", 0, 6, 32'h6, 0, 2'd0));
    x_status = 32'h0; x_redir = 1; x_rpc = 32'h3000; x_instret = 4;

    m = nop(); m.w_rd = 1; m.rd = 5; m.res = 32'h55;
    step(m, mk("eret_redir", 0, 5, 32'h55, 0, 2'd0));
    x_redir = 0;

    m = nop(); m.mtsr = 1; m.op3 = 3'd3; m.alu_res = 32'h200;
    step(m, mk("mtsr_evec", 0, 0, 32'h0, 0, 2'd0));
    x_evec = 32'h200; x_instret = 5;

    m = nop(); m.stall = 1; m.w_rd = 1; m.rd = 8; m.res = 32'h8;
    m.scall = 1; m.pc = 32'h4000; m.nextpc = 32'h4004;
    for (int i = 0; i < 3; i++) step(m, mk("stall", 0, 8, 32'h8, 0, 2'd0));
    m.stall = 0;
    step(m, mk("stall_rel", 0, 8, 32'h8, 0, 2'd0));
    x_redir = 1; x_rpc = 32'h200; x_epc = 32'h4004; x_cause = 32'h1; x_status = 32'h1;

    m = nop(); m.bubble = 1;
    step(m, mk("redir_pre_rst", 0, 0, 32'h0, 0, 2'd0));
    // Reset mid-REDIR, between clock edges.
    @(negedge clk); #1;
    rst_n = 1'b0;
    m = nop(); m.w_rd = 1; m.rd = 5; m.res = 32'h1; m.w_cr = 1;
    apply(m);
    #1;
    x_redir = 0; x_rpc = 0; x_epc = 0; x_cause = 0; x_status = 32'h1;
    x_evec = 32'h100; x_instret = 0;
    sb.push_back(mk("async_rst", 0, 5, 32'h1, 0, 2'd0));
    ->sample_now;
    #1;
    m = nop(); m.bubble = 1; apply(m);
    #1 rst_n = 1'b1;

    m = nop(); m.w_rd = 1; m.rd = 2; m.res = 32'h22;
    step(m, mk("post_rst", 1, 2, 32'h22, 0, 2'd0));
    x_instret = 1;

    m = nop(); m.bubble = 1;
    step(m, mk("post_rst_cnt", 0, 0, 32'h0, 0, 2'd0));

    repeat (3) @(negedge clk);
    #1;
    chk("end", "sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
